sprite_scheduler: RTL and testbench
===================================

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_SPRITES, 4, sprite slots.
- SPRITE_W, 32, sprite edge in pixels.
- BG_COLOR, 12'hFFF, background colour as {B,G,R}.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, pixel clock; one clock domain for the whole block.
- reset, in, 1, asynchronous, active-high.
- display_col, in, 12, current column from the VGA timing generator.
- display_row, in, 11, current row from the VGA timing generator.
- visible, in, 1, active-video flag.
- hsync_in, in, 1, horizontal sync to be delayed.
- vsync_in, in, 1, vertical sync to be delayed.
- wr_valid, in, 1, sprite-update request.
- wr_ready, out, 1, update accepted when both wr_valid and wr_ready are high.
- wr_idx, in, 2, sprite slot to update.
- wr_x, in, 12, new left edge.
- wr_y, in, 11, new top edge.
- wr_en, in, 1, slot enable.
- ram_addr, out, 12, character RAM address {idx[1:0], imgx[4:0], imgy[4:0]}.
- ram_q, in, 12, character RAM read data; synchronous, 1-cycle read latency.
- red, out, 4, pixel red.
- green, out, 4, pixel green.
- blue, out, 4, pixel blue.
- hsync, out, 1, delayed horizontal sync.
- vsync, out, 1, delayed vertical sync.

Function
REQ-003 Each slot SHALL hold a shadow register {en, x, y} and an active register {en, x, y}.
REQ-004 An accepted write SHALL update only the shadow register of slot wr_idx.
REQ-005 In the cycle where display_col==0 and display_row==0 (frame start), all shadow registers SHALL copy to the active registers and wr_ready SHALL be 0; wr_ready SHALL be 1 in every other cycle.
REQ-006 A write presented during the frame-start cycle SHALL be stalled (not lost) and accepted in the next cycle; it reaches the active registers at the following frame start.
REQ-007 Hit test per slot (stage S0): en && x <= col < x+SPRITE_W && y <= row < y+SPRITE_W.
REQ-008 The sums in REQ-007 SHALL be computed 1 bit wider than the operand so they never wrap; a sprite past the right or bottom edge is clipped, not wrapped.
REQ-009 Priority SHALL be fixed, with the lowest-index hit slot winning.
REQ-010 S1 (register stage) SHALL register ram_addr = {winner, (col-x)[4:0], (row-y)[4:0]}, together with hit_any and visible.
REQ-011 The ram_addr value registered in S1 SHALL be 0 when there is no hit.
REQ-012 S2: ram_q SHALL be valid for the address registered in S1.
REQ-013 S3: the colour registers SHALL load as follows:
- !visible → 0/0/0;
- hit_any && ram_q!=0 → red=ram_q[3:0], green=ram_q[7:4], blue=ram_q[11:8];
- otherwise → BG_COLOR (ram_q==0 is transparent; no fall-through to lower-priority sprites).
REQ-014 hsync and vsync SHALL be delayed by exactly 3 cycles so they stay aligned with the colour outputs.
REQ-015 Total latency from pixel inputs to red/green/blue SHALL be 3 clock cycles.

Reset
REQ-016 On reset:
- all shadow and active registers SHALL be 0 (every slot disabled, at 0,0);
- ram_addr and the colour outputs SHALL be 0;
- the pipeline valid/visible flags SHALL be 0;
- hsync and vsync SHALL be 0.
REQ-017 wr_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release, unless that cycle is a frame start.
REQ-018 Reset asserted mid-frame SHALL clear the registers immediately (asynchronously); the first update after release takes effect at the next frame start.

Structure
REQ-019 The package scream_pkg SHALL hold NUM_SPRITES, SPRITE_W, BG_COLOR, the screen limits H_FIELD=1279 and V_FIELD=1023, and the sprite-register record type.
REQ-020 One sub-module, sprite_hit (the per-slot comparator and offset subtractor), SHALL be instantiated NUM_SPRITES times.

Verification
REQ-021 Slot 0 enabled at (100,50), ram_q=12'h00F, pixel (110,60) at cycle t → red=F, green=0, blue=0 at t+3; ram_addr={0,10,10} at t+1.
REQ-022 Slots 1 and 2 both cover (200,200) → ram_addr[11:10]=1.
REQ-023 Slot 0 covers the pixel but ram_q=0 → output FFF; the same pixel with visible=0 → output 000.
REQ-024 Write slot 3 to (1270,1020) with en=1 → clipped: hit at col 1279 and no hit at col 0; not active before the next frame start.
REQ-025 Hold wr_valid high across a frame-start cycle → wr_ready=0 in that cycle, accepted in the next cycle, shadow updated, active register unchanged until the following frame.
REQ-026 Assert reset mid-line → all outputs 0 in the same cycle; after release with no writes, every visible pixel outputs BG_COLOR.

Source files
------------

// File: rtl/scream_pkg.sv
// Shared constants and the sprite register record for the sprite scheduler.
package scream_pkg;

    localparam int          NUM_SPRITES = 4;
    localparam int          SPRITE_W    = 32;
    localparam logic [11:0] BG_COLOR    = 12'hFFF;
    localparam int          H_FIELD     = 1279;
    localparam int          V_FIELD     = 1023;

    typedef struct packed {
        logic        en;
        logic [11:0] x;
        logic [10:0] y;
    } sprite_reg_t;

endpackage

// File: rtl/sprite_hit.sv
// Per-slot hit comparator and image-offset subtractor (combinational, stage S0).
module sprite_hit
    import scream_pkg::*;
#(
    parameter int SPRITE_W = 32
) (
    input  logic        en,
    input  logic [11:0] x,
    input  logic [10:0] y,
    input  logic [11:0] col,
    input  logic [10:0] row,
    output logic        hit,
    output logic [4:0]  off_x,
    output logic [4:0]  off_y
);

    logic [12:0] x_end;
    logic [11:0] y_end;
    logic        in_x;
    logic        in_y;
    logic        in_field;

    // One extra bit on the right/bottom edge so a sprite near the screen edge clips instead of wrapping.
    assign x_end    = {1'b0, x} + 13'(SPRITE_W);
    assign y_end    = {1'b0, y} + 12'(SPRITE_W);
    assign in_x     = (col >= x) && ({1'b0, col} < x_end);
    assign in_y     = (row >= y) && ({1'b0, row} < y_end);
    assign in_field = (int'(col) <= H_FIELD) && (int'(row) <= V_FIELD);

    assign hit   = en && in_x && in_y && in_field;
    assign off_x = 5'(col - x);
    assign off_y = 5'(row - y);

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite overlay for a VGA pixel stream: double-buffered slot registers, priority hit, 3-cycle colour pipe.
module sprite_scheduler #(
    parameter int          NUM_SPRITES = scream_pkg::NUM_SPRITES,
    parameter int          SPRITE_W    = scream_pkg::SPRITE_W,
    parameter logic [11:0] BG_COLOR    = scream_pkg::BG_COLOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        visible,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_idx,
    input  logic [11:0] wr_x,
    input  logic [10:0] wr_y,
    input  logic        wr_en,
    output logic [11:0] ram_addr,
    input  logic [11:0] ram_q,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync
);
    import scream_pkg::*;

    logic                   frame_start;
    sprite_reg_t            shadow_q [NUM_SPRITES];
    sprite_reg_t            active_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit;
    logic [4:0]             off_x [NUM_SPRITES];
    logic [4:0]             off_y [NUM_SPRITES];

    logic                   hit_any;
    logic [1:0]             winner;
    logic [4:0]             win_off_x;
    logic [4:0]             win_off_y;
    logic [11:0]            addr_s0;

    logic                   hit_s1, vis_s1;
    logic                   hit_s2, vis_s2;
    logic [11:0]            pix_q;
    logic [2:0]             hs_d, vs_d;

    assign frame_start = (display_col == 12'd0) && (display_row == 11'd0);
    assign wr_ready    = !reset && !frame_start;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wr_valid && wr_ready) begin
                shadow_q[wr_idx] <= '{en: wr_en, x: wr_x, y: wr_y};
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .SPRITE_W (SPRITE_W)
        ) u_hit (
            .en    (active_q[g].en),
            .x     (active_q[g].x),
            .y     (active_q[g].y),
            .col   (display_col),
            .row   (display_row),
            .hit   (hit[g]),
            .off_x (off_x[g]),
            .off_y (off_y[g])
        );
    end

    // Walk from the highest slot down so the lowest-index hit is the one left standing.
    always_comb begin
        hit_any   = 1'b0;
        winner    = 2'd0;
        win_off_x = 5'd0;
        win_off_y = 5'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any   = 1'b1;
                winner    = 2'(i);
                win_off_x = off_x[i];
                win_off_y = off_y[i];
            end
        end
        addr_s0 = hit_any ? {winner, win_off_x, win_off_y} : 12'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_addr <= '0;
            hit_s1   <= 1'b0;
            vis_s1   <= 1'b0;
            hit_s2   <= 1'b0;
            vis_s2   <= 1'b0;
            pix_q    <= '0;
            hs_d     <= '0;
            vs_d     <= '0;
        end else begin
            ram_addr <= addr_s0;
            hit_s1   <= hit_any;
            vis_s1   <= visible;
            hit_s2   <= hit_s1;
            vis_s2   <= vis_s1;
            hs_d     <= {hs_d[1:0], hsync_in};
            vs_d     <= {vs_d[1:0], vsync_in};
            // A zero texel is transparent to the background, never to a lower-priority sprite.
            if (!vis_s2) begin
                pix_q <= 12'd0;
            end else if (hit_s2 && (ram_q != 12'd0)) begin
                pix_q <= ram_q;
            end else begin
                pix_q <= BG_COLOR;
            end
        end
    end

    assign red   = pix_q[3:0];
    assign green = pix_q[7:4];
    assign blue  = pix_q[11:8];
    assign hsync = hs_d[2];
    assign vsync = vs_d[2];

endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomized bench for sprite_scheduler against a behavioural frame/sprite model.
module tb_sprite_scheduler;

    localparam int          SW  = 32;
    localparam logic [11:0] BG  = 12'hFFF;

    logic        clock;
    logic        reset;
    logic [11:0] display_col;
    logic [10:0] display_row;
    logic        visible;
    logic        hsync_in;
    logic        vsync_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_idx;
    logic [11:0] wr_x;
    logic [10:0] wr_y;
    logic        wr_en;
    logic [11:0] ram_addr;
    logic [11:0] ram_q;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync;

    sprite_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .display_col (display_col),
        .display_row (display_row),
        .visible     (visible),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_en       (wr_en),
        .ram_addr    (ram_addr),
        .ram_q       (ram_q),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [11:0] ram_mem [4096];
    always @(posedge clock) ram_q <= ram_mem[ram_addr];

    typedef struct {
        logic [11:0] color;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        pipe [$];
    logic [11:0] exp_addr;
    int          sh_en [4], sh_x [4], sh_y [4];
    int          act_en [4], act_x [4], act_y [4];
    logic        accepted;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_pixel(input int col, input int row, input logic vis,
                               output logic [11:0] addr, output logic [11:0] color);
        int win;
        win = -1;
        for (int s = 0; s < 4; s++) begin
            if (win < 0 && act_en[s] != 0 &&
                col >= act_x[s] && col < act_x[s] + SW &&
                row >= act_y[s] && row < act_y[s] + SW)
                win = s;
        end
        if (win >= 0) addr = 12'(win * 1024 + (col - act_x[win]) * 32 + (row - act_y[win]));
        else          addr = 12'd0;
        if (!vis)                                color = 12'd0;
        else if (win >= 0 && ram_mem[addr] != 0) color = ram_mem[addr];
        else                                     color = BG;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            sh_en[s] = 0; sh_x[s] = 0; sh_y[s] = 0;
            act_en[s] = 0; act_x[s] = 0; act_y[s] = 0;
        end
        pipe.delete();
        for (int k = 0; k < 3; k++) pipe.push_back('{color: 12'd0, hs: 1'b0, vs: 1'b0});
        exp_addr = 12'd0;
    endtask

    // Called at a falling edge: check what is due now, drive the next pixel, advance the model.
    task automatic step(input int col, input int row, input logic vis, input logic hs, input logic vs,
                        input logic wv, input int idx, input int x, input int y, input logic en);
        exp_t e;
        logic fs;
        e = pipe.pop_front();
        chk("color", {blue, green, red}, e.color);
        chk("hsync", hsync, e.hs);
        chk("vsync", vsync, e.vs);
        chk("ram_addr", ram_addr, exp_addr);
        display_col = 12'(col);
        display_row = 11'(row);
        visible     = vis;
        hsync_in    = hs;
        vsync_in    = vs;
        wr_valid    = wv;
        wr_idx      = 2'(idx);
        wr_x        = 12'(x);
        wr_y        = 11'(y);
        wr_en       = en;
        #1;
        fs = (col == 0 && row == 0);
        chk("wr_ready", wr_ready, !fs);
        accepted = wv && !fs;
        model_pixel(col, row, vis, exp_addr, e.color);
        e.hs = hs;
        e.vs = vs;
        pipe.push_back(e);
        if (fs) begin
            for (int s = 0; s < 4; s++) begin
                act_en[s] = sh_en[s]; act_x[s] = sh_x[s]; act_y[s] = sh_y[s];
            end
        end
        if (accepted) begin
            sh_en[idx] = en ? 1 : 0; sh_x[idx] = x; sh_y[idx] = y;
        end
        @(negedge clock);
    endtask

    task automatic px(input int col, input int row, input logic vis);
        step(col, row, vis, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int idx, input int x, input int y, input logic en);
        step(640, 700, 1'b1, 1'b0, 1'b0, 1'b1, idx, x, y, en);
        chk("wr_accept", accepted, 1'b1);
    endtask

    // Asserted half a cycle away from any rising edge, so only the async path can clear outputs here.
    task automatic do_reset();
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        visible  = 1'b1;
        wr_valid = 1'b1;
        reset    = 1'b1;
        #1;
        chk("reset_outs", {ram_addr, red, green, blue, hsync, vsync, wr_ready}, 32'd0);
        repeat (2) @(negedge clock);
        chk("reset_hold", {ram_addr, red, green, blue, hsync, vsync, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        reset    = 1'b0;
        model_reset();
    endtask

    initial begin
        logic        pend;
        int          p_idx, p_x, p_y, col, row, s;
        logic        p_en;

        for (int a = 0; a < 4096; a++) begin
            ram_mem[a] = ($urandom_range(0, 4) == 0) ? 12'd0 : 12'($urandom);
        end
        ram_mem[12'h14A] = 12'h00F;
        ram_mem[12'h16B] = 12'h000;

        reset = 1'b1;
        display_col = 12'd5; display_row = 11'd5;
        visible = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        wr_valid = 1'b0; wr_idx = 2'd0; wr_x = 12'd0; wr_y = 11'd0; wr_en = 1'b0;
        repeat (2) @(negedge clock);
        do_reset();

        // Single sprite, opaque texel, 3-cycle colour latency, 1-cycle address latency.
        wr(0, 100, 50, 1'b1);
        px(110, 60, 1'b1);
        chk("pre_frame_no_hit", ram_addr, 12'd0);
        px(0, 0, 1'b1);
        px(110, 60, 1'b1);
        chk("req021_addr", ram_addr, 12'h14A);
        px(700, 900, 1'b0);
        px(700, 900, 1'b0);
        chk("req021_rgb", {red, green, blue}, {4'hF, 4'h0, 4'h0});

        // Transparent texel shows background; blanking forces black.
        px(111, 61, 1'b1);
        px(111, 61, 1'b0);
        px(700, 900, 1'b1);
        chk("req023_transparent", {blue, green, red}, BG);
        px(700, 900, 1'b1);
        chk("req023_blank", {blue, green, red}, 12'h000);

        // Overlapping slots: lower index wins.
        wr(1, 190, 190, 1'b1);
        wr(2, 195, 195, 1'b1);
        px(0, 0, 1'b1);
        px(200, 200, 1'b1);
        chk("req022_winner", ram_addr[11:10], 2'd1);

        // Edge clipping, no wrap in either axis.
        wr(3, 1270, 1020, 1'b1);
        px(1279, 1021, 1'b1);
        chk("req024_inactive", ram_addr, 12'd0);
        px(0, 0, 1'b1);
        px(1279, 1021, 1'b1);
        chk("req024_hit_edge", ram_addr, 12'hD21);
        px(0, 1021, 1'b1);
        chk("req024_no_hwrap", ram_addr, 12'd0);
        px(1275, 3, 1'b1);
        chk("req024_no_vwrap", ram_addr, 12'd0);

        // Write held across a frame-start cycle is stalled then accepted.
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 300, 300, 1'b1);
        chk("req025_stalled", accepted, 1'b0);
        step(310, 310, 1'b1, 1'b0, 1'b0, 1'b1, 0, 300, 300, 1'b1);
        chk("req025_accepted", accepted, 1'b1);
        px(305, 305, 1'b1);
        chk("req025_not_active", ram_addr, 12'd0);
        px(0, 0, 1'b1);
        px(305, 305, 1'b1);
        chk("req025_active", ram_addr, 12'h0A5);

        // Randomized traffic with a well-behaved valid/ready writer.
        pend = 1'b0; p_idx = 0; p_x = 0; p_y = 0; p_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend  = 1'b1;
                p_idx = int'($urandom_range(0, 3));
                p_x   = int'($urandom_range(0, 1279));
                p_y   = int'($urandom_range(0, 1023));
                p_en  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 19) == 0) begin
                col = 0; row = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                s   = int'($urandom_range(0, 3));
                col = act_x[s] + int'($urandom_range(0, 40)) - 4;
                row = act_y[s] + int'($urandom_range(0, 40)) - 4;
                if (col < 0) col = 0;
                if (col > 1279) col = 1279;
                if (row < 0) row = 0;
                if (row > 1023) row = 1023;
            end else begin
                col = int'($urandom_range(0, 1279));
                row = int'($urandom_range(0, 1023));
            end
            step(col, row, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), pend, p_idx, p_x, p_y, p_en);
            if (accepted) pend = 1'b0;
        end

        // Mid-line reset, then every visible pixel is background.
        px(400, 400, 1'b1);
        do_reset();
        px(100, 60, 1'b1);
        px(0, 0, 1'b1);
        px(200, 200, 1'b1);
        px(310, 310, 1'b1);
        chk("req026_bg", {blue, green, red}, BG);
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 19) == 0) px(0, 0, 1'b1);
            else px(int'($urandom_range(0, 1279)), int'($urandom_range(0, 1023)), 1'b1);
        end
        repeat (3) px(50, 50, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
